// File: rtl/arm_hps_system_multi_interval_timer.sv
// rtl/arm_hps_system_multi_interval_timer.sv - multi-channel Avalon-MM interval timer
//
// Purpose: NUM_CH independent down-counters with a shared clock prescaler.
//   Each channel runs one-shot or continuous, and has its own period,
//   snapshot, timeout flag and interrupt enable. The per-channel interrupts
//   are ORed onto a single level irq.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   address    - word address; channel c occupies 4c..4c+3, PRESC at NUM_CH*4
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - registered read data, valid one clock after address
//   irq        - OR over channels of (TO & ITO)
module arm_hps_system_multi_interval_timer #(
  parameter int          NUM_CH       = 4,
  parameter int          COUNT_W      = 32,
  parameter int          PRESC_W      = 16,
  parameter logic [31:0] RESET_PERIOD = 32'h005F_5E0F,
  localparam int         AW           = $clog2(NUM_CH * 4 + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          irq
);

  localparam logic [COUNT_W-1:0] RST_CNT    = RESET_PERIOD[COUNT_W-1:0];
  localparam logic [AW-1:0]      PRESC_ADDR = AW'(NUM_CH * 4);

  // CONTROL bit positions
  localparam int C_ITO   = 0;
  localparam int C_CONT  = 1;
  localparam int C_START = 2;
  localparam int C_STOP  = 3;

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;

  logic [COUNT_W-1:0] period [NUM_CH];
  logic [COUNT_W-1:0] cnt    [NUM_CH];
  logic [COUNT_W-1:0] snap   [NUM_CH];
  logic [3:0]         ctrl   [NUM_CH];
  logic [NUM_CH-1:0]  run;
  logic [NUM_CH-1:0]  to;

  logic               wr_en;
  logic               wr_presc;
  logic [NUM_CH-1:0]  wr_stat;
  logic [NUM_CH-1:0]  wr_ctl;
  logic [NUM_CH-1:0]  wr_per;
  logic [NUM_CH-1:0]  wr_snap;
  logic [NUM_CH-1:0]  timeout;
  logic [NUM_CH-1:0]  decr;
  logic [NUM_CH-1:0]  irq_vec;
  logic [31:0]        rd_mux;

  assign wr_en    = chipselect & ~write_n;
  assign wr_presc = wr_en && (address == PRESC_ADDR);
  assign tick     = (presc_cnt == '0);
  assign irq      = |irq_vec;

  // Write decode and per-channel tick events
  always_comb begin
    wr_stat = '0;
    wr_ctl  = '0;
    wr_per  = '0;
    wr_snap = '0;
    timeout = '0;
    decr    = '0;
    irq_vec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_stat[c] = wr_en && (address == AW'(4 * c));
      wr_ctl[c]  = wr_en && (address == AW'(4 * c + 1));
      wr_per[c]  = wr_en && (address == AW'(4 * c + 2));
      wr_snap[c] = wr_en && (address == AW'(4 * c + 3));
      timeout[c] = tick && run[c] && (cnt[c] == '0);
      decr[c]    = tick && run[c] && (cnt[c] != '0);
      irq_vec[c] = to[c] && ctrl[c][C_ITO];
    end
  end

  // Read mux; unmapped addresses fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (address == AW'(4 * c))     rd_mux[1:0]         = {run[c], to[c]};
      if (address == AW'(4 * c + 1)) rd_mux[3:0]         = ctrl[c];
      if (address == AW'(4 * c + 2)) rd_mux[COUNT_W-1:0] = period[c];
      if (address == AW'(4 * c + 3)) rd_mux[COUNT_W-1:0] = snap[c];
    end
    if (address == PRESC_ADDR) rd_mux[PRESC_W-1:0] = presc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata  <= '0;
      presc     <= '0;
      presc_cnt <= '0;
      run       <= '0;
      to        <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        period[c] <= RST_CNT;
        cnt[c]    <= RST_CNT;
        snap[c]   <= '0;
        ctrl[c]   <= '0;
      end
    end else begin
      readdata <= rd_mux;

      // A PRESC write restarts the prescaler phase without emitting a tick
      if (wr_presc) begin
        presc     <= writedata[PRESC_W-1:0];
        presc_cnt <= writedata[PRESC_W-1:0];
      end else if (tick) begin
        presc_cnt <= presc;
      end else begin
        presc_cnt <= presc_cnt - PRESC_W'(1);
      end

      for (int c = 0; c < NUM_CH; c++) begin
        // A timeout always lands, even against a same-cycle clear
        if (timeout[c])      to[c] <= 1'b1;
        else if (wr_stat[c]) to[c] <= 1'b0;

        // PERIOD write force-reloads and beats the tick
        if (wr_per[c]) begin
          period[c] <= writedata[COUNT_W-1:0];
          cnt[c]    <= writedata[COUNT_W-1:0];
        end else if (timeout[c]) begin
          cnt[c] <= period[c];
        end else if (decr[c]) begin
          cnt[c] <= cnt[c] - COUNT_W'(1);
        end

        // Priority: PERIOD write stop > START > STOP > timeout (one-shot stop)
        if (wr_per[c])                             run[c] <= 1'b0;
        else if (wr_ctl[c] && writedata[C_START])  run[c] <= 1'b1;
        else if (wr_ctl[c] && writedata[C_STOP])   run[c] <= 1'b0;
        else if (timeout[c])                       run[c] <= ctrl[c][C_CONT];

        if (wr_ctl[c])  ctrl[c] <= writedata[3:0];
        if (wr_snap[c]) snap[c] <= cnt[c];
      end
    end
  end

endmodule
